blkdev_requester: RTL and testbench

Initiator side of the block-device protocol: accepts one sector-granular command from a host, issues it on the `bdev_req` channel, streams write data out on `bdev_data`, and collects read data or the write ack from `bdev_resp`. It sits between a host engine (DMA or MMIO front end) and any block-device responder. It range-checks every command against the responder's `bdev_info_*` outputs and reports one completion per command. One command is outstanding at a time.

---
 rtl/blkdev_requester_pkg.sv | 25 ++
 rtl/blkdev_requester_if.sv | 87 ++++++++
 rtl/blkdev_requester_watchdog.sv | 28 ++
 rtl/blkdev_requester.sv | 175 +++++++++++++++++
 tb/tb_blkdev_requester.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/blkdev_requester_pkg.sv
// blkdev_pkg: shared constants and enums for the block-device requester.
package blkdev_pkg;

    localparam int BLKDEV_SECTOR_BITS = 32;
    localparam int BLKDEV_DATA_BITS   = 64;
    // 512-byte sector / 8-byte beat = 64 beats per sector
    localparam int BLKDEV_BEATS_LOG2  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WDATA,
        ST_WACK,
        ST_RDATA,
        ST_DONE
    } blkdev_state_e;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'd0,
        STATUS_RANGE   = 2'd1,
        STATUS_TAGERR  = 2'd2,
        STATUS_TIMEOUT = 2'd3
    } blkdev_status_e;

endpackage

// File: rtl/blkdev_requester_if.sv
// Host-side and device-side channels of the block-device requester.
// master: the requester itself; slave: host engine plus device model.
interface blkdev_requester_if #(
    parameter int TAG_BITS    = 1,
    parameter int SECTOR_BITS = 32,
    parameter int DATA_BITS   = 64
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_bits_write;
    logic [SECTOR_BITS-1:0] cmd_bits_offset;
    logic [SECTOR_BITS-1:0] cmd_bits_len;
    logic [TAG_BITS-1:0]    cmd_bits_tag;

    logic                   wdata_valid;
    logic                   wdata_ready;
    logic [DATA_BITS-1:0]   wdata_bits;

    logic                   rdata_valid;
    logic                   rdata_ready;
    logic [DATA_BITS-1:0]   rdata_bits_data;
    logic                   rdata_bits_last;

    logic                   cmpl_valid;
    logic                   cmpl_ready;
    logic [TAG_BITS-1:0]    cmpl_bits_tag;
    logic [1:0]             cmpl_bits_status;

    logic                   bdev_req_valid;
    logic                   bdev_req_ready;
    logic                   bdev_req_bits_write;
    logic [SECTOR_BITS-1:0] bdev_req_bits_offset;
    logic [SECTOR_BITS-1:0] bdev_req_bits_len;
    logic [TAG_BITS-1:0]    bdev_req_bits_tag;

    logic                   bdev_data_valid;
    logic                   bdev_data_ready;
    logic [DATA_BITS-1:0]   bdev_data_bits_data;
    logic [TAG_BITS-1:0]    bdev_data_bits_tag;

    logic                   bdev_resp_valid;
    logic                   bdev_resp_ready;
    logic [DATA_BITS-1:0]   bdev_resp_bits_data;
    logic [TAG_BITS-1:0]    bdev_resp_bits_tag;

    logic [SECTOR_BITS-1:0] bdev_info_nsectors;
    logic [SECTOR_BITS-1:0] bdev_info_max_req_len;

    modport master (
        input  cmd_valid, cmd_bits_write, cmd_bits_offset, cmd_bits_len, cmd_bits_tag,
        output cmd_ready,
        input  wdata_valid, wdata_bits,
        output wdata_ready,
        output rdata_valid, rdata_bits_data, rdata_bits_last,
        input  rdata_ready,
        output cmpl_valid, cmpl_bits_tag, cmpl_bits_status,
        input  cmpl_ready,
        output bdev_req_valid, bdev_req_bits_write, bdev_req_bits_offset,
               bdev_req_bits_len, bdev_req_bits_tag,
        input  bdev_req_ready,
        output bdev_data_valid, bdev_data_bits_data, bdev_data_bits_tag,
        input  bdev_data_ready,
        input  bdev_resp_valid, bdev_resp_bits_data, bdev_resp_bits_tag,
        output bdev_resp_ready,
        input  bdev_info_nsectors, bdev_info_max_req_len
    );

    modport slave (
        output cmd_valid, cmd_bits_write, cmd_bits_offset, cmd_bits_len, cmd_bits_tag,
        input  cmd_ready,
        output wdata_valid, wdata_bits,
        input  wdata_ready,
        input  rdata_valid, rdata_bits_data, rdata_bits_last,
        output rdata_ready,
        input  cmpl_valid, cmpl_bits_tag, cmpl_bits_status,
        output cmpl_ready,
        input  bdev_req_valid, bdev_req_bits_write, bdev_req_bits_offset,
               bdev_req_bits_len, bdev_req_bits_tag,
        output bdev_req_ready,
        input  bdev_data_valid, bdev_data_bits_data, bdev_data_bits_tag,
        output bdev_data_ready,
        output bdev_resp_valid, bdev_resp_bits_data, bdev_resp_bits_tag,
        input  bdev_resp_ready,
        output bdev_info_nsectors, bdev_info_max_req_len
    );

endinterface

// File: rtl/blkdev_requester_watchdog.sv
// blkdev_watchdog: idle-cycle counter; expire is high on the cycle the
// count reaches TIMEOUT_CYCLES-1 while enabled.
module blkdev_watchdog #(
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int WCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WCW-1:0] count;

    assign expire = enable && (count == WCW'(TIMEOUT_CYCLES - 1));

    // Count enabled cycles; hold at the limit, restart on clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !expire)
            count <= count + WCW'(1);
    end

endmodule

// File: rtl/blkdev_requester.sv
// blkdev_requester: issues one sector-granular host command at a time to a
// block device, streams write data / read data, and reports a completion.
// Optional watchdog: define BLKDEV_REQUESTER_TIMEOUT_EN to abort stalled
// transfers with status TIMEOUT after TIMEOUT_CYCLES idle cycles.
module blkdev_requester
    import blkdev_pkg::*;
#(
    parameter int TAG_BITS       = 1,
    parameter int SECTOR_BITS    = BLKDEV_SECTOR_BITS,
    parameter int DATA_BITS      = BLKDEV_DATA_BITS,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic              clock,
    input  logic              reset_n,
    blkdev_requester_if.master bus
);
    localparam int CW = SECTOR_BITS + BLKDEV_BEATS_LOG2;

    blkdev_state_e          state;
    blkdev_status_e         status;
    logic [1:0]             init_sr;
    logic                   wr_q;
    logic [SECTOR_BITS-1:0] off_q;
    logic [SECTOR_BITS-1:0] len_q;
    logic [TAG_BITS-1:0]    tag_q;
    logic [CW-1:0]          beats;

    logic st_req, st_wdata, st_wack, st_rdata, st_done;
    assign st_req   = (state == ST_REQ);
    assign st_wdata = (state == ST_WDATA);
    assign st_wack  = (state == ST_WACK);
    assign st_rdata = (state == ST_RDATA);
    assign st_done  = (state == ST_DONE);

    // Host command side; cmd_ready waits two edges after reset release.
    assign bus.cmd_ready = (state == ST_IDLE) && init_sr[1];

    // Device request channel, fields held in the latch registers until fire.
    assign bus.bdev_req_valid       = st_req;
    assign bus.bdev_req_bits_write  = wr_q;
    assign bus.bdev_req_bits_offset = off_q;
    assign bus.bdev_req_bits_len    = len_q;
    assign bus.bdev_req_bits_tag    = tag_q;

    // Write stream pass-through, gated to WDATA.
    assign bus.bdev_data_valid     = st_wdata && bus.wdata_valid;
    assign bus.wdata_ready         = st_wdata && bus.bdev_data_ready;
    assign bus.bdev_data_bits_data = st_wdata ? bus.wdata_bits : '0;
    assign bus.bdev_data_bits_tag  = tag_q;

    // Read stream pass-through; WACK swallows exactly one ack beat.
    assign bus.bdev_resp_ready = st_wack || (st_rdata && bus.rdata_ready);
    assign bus.rdata_valid     = st_rdata && bus.bdev_resp_valid;
    assign bus.rdata_bits_data = st_rdata ? bus.bdev_resp_bits_data : '0;
    assign bus.rdata_bits_last = st_rdata && (beats == CW'(1));

    assign bus.cmpl_valid       = st_done;
    assign bus.cmpl_bits_tag    = tag_q;
    assign bus.cmpl_bits_status = status;

    logic cmd_fire, req_fire, data_fire, resp_fire, cmpl_fire, last_beat;
    assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
    assign req_fire  = bus.bdev_req_valid && bus.bdev_req_ready;
    assign data_fire = bus.bdev_data_valid && bus.bdev_data_ready;
    assign resp_fire = bus.bdev_resp_valid && bus.bdev_resp_ready;
    assign cmpl_fire = bus.cmpl_valid && bus.cmpl_ready;
    assign last_beat = (beats == CW'(1));

    // Range check: end sector computed one bit wider so it cannot wrap.
    logic [SECTOR_BITS:0] end_sec;
    logic                 range_err;
    assign end_sec   = {1'b0, bus.cmd_bits_offset} + {1'b0, bus.cmd_bits_len};
    assign range_err = (bus.cmd_bits_len == '0)
                    || (bus.cmd_bits_len > bus.bdev_info_max_req_len)
                    || (end_sec > {1'b0, bus.bdev_info_nsectors});

    logic tag_bad;
    assign tag_bad = (bus.bdev_resp_bits_tag != tag_q);

    logic timeout;
`ifdef BLKDEV_REQUESTER_TIMEOUT_EN
    logic wd_en, wd_clr;
    assign wd_en  = st_req || st_wdata || st_wack || st_rdata;
    // Clearing outside the watched states covers the state-entry restart.
    assign wd_clr = !wd_en || req_fire || data_fire || resp_fire;

    blkdev_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (wd_clr),
        .enable  (wd_en),
        .expire  (timeout)
    );
`else
    assign timeout = 1'b0;
    logic unused_timeout_param;
    assign unused_timeout_param = ^TIMEOUT_CYCLES;
`endif

    // Command FSM: latch, issue, stream, collect, complete. A fire always
    // takes priority over watchdog expiry in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            status  <= STATUS_OK;
            init_sr <= 2'b00;
            wr_q    <= 1'b0;
            off_q   <= '0;
            len_q   <= '0;
            tag_q   <= '0;
            beats   <= '0;
        end else begin
            init_sr <= {init_sr[0], 1'b1};
            case (state)
                ST_IDLE: if (cmd_fire) begin
                    wr_q  <= bus.cmd_bits_write;
                    off_q <= bus.cmd_bits_offset;
                    len_q <= bus.cmd_bits_len;
                    tag_q <= bus.cmd_bits_tag;
                    beats <= {bus.cmd_bits_len, {BLKDEV_BEATS_LOG2{1'b0}}};
                    if (range_err) begin
                        status <= STATUS_RANGE;
                        state  <= ST_DONE;
                    end else begin
                        status <= STATUS_OK;
                        state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (req_fire)
                        state <= wr_q ? ST_WDATA : ST_RDATA;
                    else if (timeout) begin
                        status <= STATUS_TIMEOUT;
                        state  <= ST_DONE;
                    end
                end
                ST_WDATA: begin
                    if (data_fire) begin
                        beats <= beats - CW'(1);
                        if (last_beat)
                            state <= ST_WACK;
                    end else if (timeout) begin
                        status <= STATUS_TIMEOUT;
                        state  <= ST_DONE;
                    end
                end
                ST_WACK: begin
                    if (resp_fire) begin
                        if (tag_bad)
                            status <= STATUS_TAGERR;
                        state <= ST_DONE;
                    end else if (timeout) begin
                        status <= STATUS_TIMEOUT;
                        state  <= ST_DONE;
                    end
                end
                ST_RDATA: begin
                    if (resp_fire) begin
                        beats <= beats - CW'(1);
                        if (tag_bad)
                            status <= STATUS_TAGERR;
                        if (last_beat)
                            state <= ST_DONE;
                    end else if (timeout) begin
                        status <= STATUS_TIMEOUT;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: if (cmpl_fire) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blkdev_requester.sv
// Directed bench for blkdev_requester: read, write with random stalls,
// range errors, tag error, watchdog (or indefinite REQ stall), reset mid-read.
module tb_blkdev_requester;
    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    blkdev_requester_if #(.TAG_BITS(1), .SECTOR_BITS(32), .DATA_BITS(64)) bif ();

    blkdev_requester #(
        .TAG_BITS(1), .SECTOR_BITS(32), .DATA_BITS(64), .TIMEOUT_CYCLES(100)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL tb_watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic w, input int off, input int len, input logic tg);
        bif.cmd_bits_write  = w;
        bif.cmd_bits_offset = off;
        bif.cmd_bits_len    = len;
        bif.cmd_bits_tag    = tg;
        bif.cmd_valid       = 1'b1;
        #1;
        chk("cmd_ready", bif.cmd_ready, 1);
        tick();
        bif.cmd_valid = 1'b0;
    endtask

    // Device returns beats A000+i; every 7th beat the host stalls one cycle.
    task automatic read_beats(input int n, input int total, input logic rtag);
        for (int i = 0; i < n; i++) begin
            bif.bdev_resp_valid     = 1'b1;
            bif.bdev_resp_bits_tag  = rtag;
            bif.bdev_resp_bits_data = 64'hA000 + 64'(i);
            if (i % 7 == 3) begin
                bif.rdata_ready = 1'b0;
                #1;
                chk("rd_stall_ready", bif.bdev_resp_ready, 0);
                tick();
            end
            bif.rdata_ready = 1'b1;
            #1;
            chk("rd_valid", bif.rdata_valid, 1);
            chk("rd_data", bif.rdata_bits_data, 64'hA000 + 64'(i));
            chk("rd_last", bif.rdata_bits_last, (i == total - 1) ? 1 : 0);
            tick();
        end
        bif.bdev_resp_valid = 1'b0;
        bif.rdata_ready     = 1'b0;
    endtask

    task automatic finish_cmpl(input logic tg, input int st);
        #1;
        chk("cmpl_valid", bif.cmpl_valid, 1);
        chk("cmpl_tag", bif.cmpl_bits_tag, tg);
        chk("cmpl_status", bif.cmpl_bits_status, st);
        bif.cmpl_ready = 1'b1;
        tick();
        bif.cmpl_ready = 1'b0;
        #1;
        chk("cmpl_drop", bif.cmpl_valid, 0);
        chk("cmd_ready_again", bif.cmd_ready, 1);
    endtask

    task automatic issue_req(input logic w, input int off, input int len, input logic tg);
        send_cmd(w, off, len, tg);
        #1;
        chk("req_valid", bif.bdev_req_valid, 1);
        chk("req_write", bif.bdev_req_bits_write, w);
        chk("req_offset", bif.bdev_req_bits_offset, off);
        chk("req_len", bif.bdev_req_bits_len, len);
        chk("req_tag", bif.bdev_req_bits_tag, tg);
        bif.bdev_req_ready = 1'b1;
        tick();
        bif.bdev_req_ready = 1'b0;
    endtask

    initial begin
        int sent;
        int got;
        logic wv, dr;
        rst_n = 1'b0;
        bif.cmd_valid = 0; bif.cmd_bits_write = 0; bif.cmd_bits_offset = 0;
        bif.cmd_bits_len = 0; bif.cmd_bits_tag = 0;
        bif.wdata_valid = 0; bif.wdata_bits = 0; bif.rdata_ready = 0; bif.cmpl_ready = 0;
        bif.bdev_req_ready = 0; bif.bdev_data_ready = 0; bif.bdev_resp_valid = 0;
        bif.bdev_resp_bits_data = 0; bif.bdev_resp_bits_tag = 0;
        bif.bdev_info_nsectors = 16; bif.bdev_info_max_req_len = 4;

        // Reset state
        #1;
        chk("rst_cmd_ready", bif.cmd_ready, 0);
        chk("rst_req_valid", bif.bdev_req_valid, 0);
        chk("rst_data_valid", bif.bdev_data_valid, 0);
        chk("rst_wdata_ready", bif.wdata_ready, 0);
        chk("rst_rdata_valid", bif.rdata_valid, 0);
        chk("rst_resp_ready", bif.bdev_resp_ready, 0);
        chk("rst_cmpl_valid", bif.cmpl_valid, 0);
        chk("rst_cmpl_status", bif.cmpl_bits_status, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rel_edge1_cmd_ready", bif.cmd_ready, 0);
        tick();
        chk("rel_edge2_cmd_ready", bif.cmd_ready, 1);

        // Read offset 2 len 1 tag 1
        issue_req(1'b0, 2, 1, 1'b1);
        read_beats(64, 64, 1'b1);
        finish_cmpl(1'b1, 0);

        // Write offset 0 len 2 tag 0 with random stalls on both sides
        issue_req(1'b1, 0, 2, 1'b0);
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 3000 && got < 128; cyc++) begin
            wv = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            bif.wdata_valid     = wv;
            bif.wdata_bits      = 64'hB000 + 64'(sent);
            bif.bdev_data_ready = dr;
            #1;
            chk("wr_pass_valid", bif.bdev_data_valid, wv);
            chk("wr_pass_ready", bif.wdata_ready, dr);
            if (bif.bdev_data_valid && bif.bdev_data_ready) begin
                chk("wr_data", bif.bdev_data_bits_data, 64'hB000 + 64'(got));
                chk("wr_tag", bif.bdev_data_bits_tag, 0);
                got++;
            end
            if (wv && bif.wdata_ready) sent++;
            tick();
        end
        chk("wr_beats", got, 128);
        bif.wdata_valid = 1'b1;
        bif.bdev_data_ready = 1'b1;
        #1;
        chk("wr_no_extra_beat", bif.bdev_data_valid, 0);
        chk("wr_ack_ready", bif.bdev_resp_ready, 1);
        bif.wdata_valid = 1'b0;
        bif.bdev_data_ready = 1'b0;
        bif.bdev_resp_valid = 1'b1;
        bif.bdev_resp_bits_tag = 1'b0;
        tick();
        bif.bdev_resp_valid = 1'b0;
        finish_cmpl(1'b0, 0);

        // Range errors: len 0, len 5 > max 4, offset 15 + len 2 > 16
        send_cmd(1'b0, 0, 0, 1'b1);
        #1; chk("rng_len0_req", bif.bdev_req_valid, 0);
        finish_cmpl(1'b1, 1);
        send_cmd(1'b1, 0, 5, 1'b0);
        #1; chk("rng_max_req", bif.bdev_req_valid, 0);
        finish_cmpl(1'b0, 1);
        send_cmd(1'b0, 15, 2, 1'b1);
        #1; chk("rng_end_req", bif.bdev_req_valid, 0);
        finish_cmpl(1'b1, 1);
        bif.bdev_info_nsectors = 0;
        send_cmd(1'b0, 0, 1, 1'b0);
        #1; chk("rng_nsec0_req", bif.bdev_req_valid, 0);
        finish_cmpl(1'b0, 1);
        bif.bdev_info_nsectors = 16;

        // Tag error on a boundary read (offset 15 len 1 ends exactly at 16)
        issue_req(1'b0, 15, 1, 1'b1);
        read_beats(64, 64, 1'b0);
        finish_cmpl(1'b1, 2);

        // Device never accepts the request
        send_cmd(1'b0, 1, 1, 1'b0);
`ifdef BLKDEV_REQUESTER_TIMEOUT_EN
        for (int i = 0; i < 99; i++) tick();
        chk("to_not_yet", bif.cmpl_valid, 0);
        tick();
        chk("to_req_dropped", bif.bdev_req_valid, 0);
        finish_cmpl(1'b0, 3);
`else
        for (int i = 0; i < 200; i++) tick();
        chk("stall_req_valid", bif.bdev_req_valid, 1);
        chk("stall_no_cmpl", bif.cmpl_valid, 0);
        bif.bdev_req_ready = 1'b1;
        tick();
        bif.bdev_req_ready = 1'b0;
        read_beats(64, 64, 1'b0);
        finish_cmpl(1'b0, 0);
`endif

        // Reset in the middle of a read
        issue_req(1'b0, 3, 2, 1'b1);
        read_beats(10, 128, 1'b1);
        bif.bdev_resp_valid = 1'b1;
        bif.bdev_resp_bits_data = 64'hDEAD;
        bif.rdata_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdata_valid", bif.rdata_valid, 0);
        chk("mid_rst_resp_ready", bif.bdev_resp_ready, 0);
        chk("mid_rst_rdata_data", bif.rdata_bits_data, 0);
        chk("mid_rst_rdata_last", bif.rdata_bits_last, 0);
        chk("mid_rst_cmd_ready", bif.cmd_ready, 0);
        chk("mid_rst_req_offset", bif.bdev_req_bits_offset, 0);
        chk("mid_rst_cmpl_valid", bif.cmpl_valid, 0);
        bif.bdev_resp_valid = 1'b0;
        bif.rdata_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rel_edge1", bif.cmd_ready, 0);
        tick();
        chk("mid_rel_edge2", bif.cmd_ready, 1);
        chk("mid_rel_no_cmpl", bif.cmpl_valid, 0);
        issue_req(1'b0, 0, 1, 1'b0);
        read_beats(64, 64, 1'b0);
        finish_cmpl(1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
